// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine: shift-add MULT/MULTU, restoring DIV/DIVU.
module mult_div_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             mult_div_done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_SIGN,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic [WIDTH-1:0]     opnd;       // multiplicand or divisor magnitude
    logic [DW-1:0]        acc;        // product accumulator; low half is dividend/quotient
    logic [WIDTH:0]       rem;        // partial remainder
    logic [WIDTH-1:0]     op1_latch;  // original dividend, returned on divide by zero
    logic                 is_div;
    logic                 neg_main;
    logic                 neg_rem;
    logic                 dz;

    logic                 accept;
    logic [WIDTH-1:0]     op1_mag;
    logic [WIDTH-1:0]     op2_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_sub;
    logic                 div_borrow;
    logic [DW-1:0]        prod_final;
    logic [WIDTH-1:0]     quo_final;
    logic [WIDTH-1:0]     rem_final;

    // Operand magnitudes and per-iteration datapath arithmetic
    always_comb begin
        accept     = (state == S_IDLE) && (mult_start || div_start);
        op1_mag    = (is_signed && Operand1[WIDTH-1]) ? -Operand1 : Operand1;
        op2_mag    = (is_signed && Operand2[WIDTH-1]) ? -Operand2 : Operand2;
        mul_sum    = {1'b0, acc[DW-1:WIDTH]} + {1'b0, (acc[0] ? opnd : WIDTH'(0))};
        div_sub    = {rem, acc[WIDTH-1]} - {2'b00, opnd};
        div_borrow = div_sub[WIDTH+1];
        prod_final = neg_main ? -acc : acc;
        quo_final  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_final  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (mult_start)      state_nxt = S_MULT;
                else if (div_start)  state_nxt = S_DIV;
            end
            S_MULT, S_DIV: begin
                if (cnt == CNT_WIDTH'(WIDTH - 1)) state_nxt = S_SIGN;
            end
            S_SIGN:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, iteration datapath and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= S_IDLE;
            cnt           <= '0;
            opnd          <= '0;
            acc           <= '0;
            rem           <= '0;
            op1_latch     <= '0;
            is_div        <= 1'b0;
            neg_main      <= 1'b0;
            neg_rem       <= 1'b0;
            dz            <= 1'b0;
            hi_out        <= '0;
            lo_out        <= '0;
            mult_div_done <= 1'b0;
            busy          <= 1'b0;
            div_by_zero   <= 1'b0;
        end else begin
            state         <= state_nxt;
            busy          <= (state_nxt != S_IDLE);
            mult_div_done <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        rem         <= '0;
                        op1_latch   <= Operand1;
                        is_div      <= !mult_start;
                        neg_main    <= is_signed & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
                        neg_rem     <= is_signed & Operand1[WIDTH-1];
                        dz          <= !mult_start && (Operand2 == '0);
                        if (mult_start) begin
                            opnd <= op1_mag;
                            acc  <= {WIDTH'(0), op2_mag};
                        end else begin
                            opnd <= op2_mag;
                            acc  <= {WIDTH'(0), op1_mag};
                        end
                    end
                end
                S_MULT: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + CNT_WIDTH'(1);
                end
                S_DIV: begin
                    if (div_borrow) begin
                        rem <= {rem[WIDTH-1:0], acc[WIDTH-1]};
                        acc <= {acc[DW-1:WIDTH], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        rem <= div_sub[WIDTH:0];
                        acc <= {acc[DW-1:WIDTH], acc[WIDTH-2:0], 1'b1};
                    end
                    cnt <= cnt + CNT_WIDTH'(1);
                end
                S_SIGN: begin
                    if (!is_div) begin
                        hi_out <= prod_final[DW-1:WIDTH];
                        lo_out <= prod_final[WIDTH-1:0];
                    end else if (dz) begin
                        hi_out      <= op1_latch;
                        lo_out      <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi_out <= rem_final;
                        lo_out <= quo_final;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit.
module tb_mult_div_unit;

    logic        CLK;
    logic        RST;
    logic        mult_start;
    logic        div_start;
    logic        is_signed;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        mult_div_done;
    logic        busy;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    mult_div_unit #(.WIDTH(32), .CNT_WIDTH(6)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .mult_start    (mult_start),
        .div_start     (div_start),
        .is_signed     (is_signed),
        .Operand1      (Operand1),
        .Operand2      (Operand2),
        .hi_out        (hi_out),
        .lo_out        (lo_out),
        .mult_div_done (mult_div_done),
        .busy          (busy),
        .div_by_zero   (div_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble operands to prove they were latched
    task automatic issue(input logic m, input logic d, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        mult_start = m;
        div_start  = d;
        is_signed  = s;
        Operand1   = a;
        Operand2   = b;
        @(posedge CLK);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        is_signed  = ~s;
        Operand1   = 32'hDEAD_BEEF;
        Operand2   = 32'h0BAD_F00D;
    endtask

    // Wait for done (bounded), check its edge count from the start edge and its width
    task automatic wait_done(input string tag, input int k0);
        int k;
        bit seen;
        k    = k0;
        seen = 1'b0;
        while (k < 100 && !seen) begin
            @(posedge CLK);
            #1;
            k++;
            if (mult_div_done) seen = 1'b1;
        end
        check({tag, " latency"}, 64'(k), 64'd33);
        @(posedge CLK);
        #1;
        check({tag, " done width"}, 64'(mult_div_done), 64'd0);
        check({tag, " busy after"}, 64'(busy), 64'd0);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            #1;
            if (mult_div_done) n++;
        end
    endtask

    initial begin
        int n_done;
        RST        = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        is_signed  = 1'b0;
        Operand1   = '0;
        Operand2   = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset hi", 64'(hi_out), 64'd0);
        check("reset lo", 64'(lo_out), 64'd0);
        check("reset done", 64'(mult_div_done), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset dz", 64'(div_by_zero), 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        // MULTU max x max
        issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu busy", 64'(busy), 64'd1);
        wait_done("multu", 0);
        check("multu hi", 64'(hi_out), 64'hFFFF_FFFE);
        check("multu lo", 64'(lo_out), 64'h0000_0001);

        // MULT -7 x 3, with previous result held and a div_start pulsed while busy
        issue(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd3);
        for (int i = 1; i <= 10; i++) begin
            @(posedge CLK);
            #1;
            if (i == 5) div_start = 1'b1;
            if (i == 6) div_start = 1'b0;
        end
        check("hold hi", 64'(hi_out), 64'hFFFF_FFFE);
        check("hold lo", 64'(lo_out), 64'h0000_0001);
        check("hold busy", 64'(busy), 64'd1);
        wait_done("mult neg", 10);
        check("mult neg hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("mult neg lo", 64'(lo_out), 64'hFFFF_FFEB);
        count_done(40, n_done);
        check("ignored div done count", 64'(n_done), 64'd0);
        check("ignored div hi", 64'(hi_out), 64'hFFFF_FFFF);

        // MULT -1 x -1
        issue(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mult m1", 0);
        check("mult m1 hi", 64'(hi_out), 64'd0);
        check("mult m1 lo", 64'(lo_out), 64'd1);

        // DIV -7 / 2
        issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("div neg", 0);
        check("div neg lo", 64'(lo_out), 64'hFFFF_FFFD);
        check("div neg hi", 64'(hi_out), 64'hFFFF_FFFF);
        check("div neg dz", 64'(div_by_zero), 64'd0);

        // DIVU 100 / 7
        issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        wait_done("divu", 0);
        check("divu lo", 64'(lo_out), 64'd14);
        check("divu hi", 64'(hi_out), 64'd2);

        // DIVU by zero
        issue(1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'd0);
        wait_done("divz", 0);
        check("divz lo", 64'(lo_out), 64'hFFFF_FFFF);
        check("divz hi", 64'(hi_out), 64'h0000_1234);
        check("divz flag", 64'(div_by_zero), 64'd1);
        repeat (3) @(posedge CLK);
        #1;
        check("divz flag held", 64'(div_by_zero), 64'd1);

        // DIV min / -1, flag cleared by the new start
        issue(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        check("dz cleared", 64'(div_by_zero), 64'd0);
        wait_done("div ovf", 0);
        check("div ovf lo", 64'(lo_out), 64'h8000_0000);
        check("div ovf hi", 64'(hi_out), 64'd0);

        // Both starts high: multiply wins
        issue(1'b1, 1'b1, 1'b0, 32'd6, 32'd4);
        wait_done("both", 0);
        check("both hi", 64'(hi_out), 64'd0);
        check("both lo", 64'(lo_out), 64'd24);
        count_done(40, n_done);
        check("both extra done", 64'(n_done), 64'd0);

        // Reset mid-multiply aborts without a done pulse
        issue(1'b1, 1'b0, 1'b0, 32'd5, 32'd5);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi_out), 64'd0);
        check("abort lo", 64'(lo_out), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        count_done(40, n_done);
        check("abort done count", 64'(n_done), 64'd0);

        // Normal operation after the abort
        issue(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
        wait_done("post reset", 0);
        check("post reset hi", 64'(hi_out), 64'd0);
        check("post reset lo", 64'(lo_out), 64'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
